// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls the front end while busy.
// Optional `MULDIV_FAST_MUL_EN` gives MUL* ops a single-cycle product path.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] Data1,
  input  logic [XLEN-1:0] Data2,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Operand decode for the incoming instruction
  logic            is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in, res_neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div_in   = func3[2];
    a_signed_in = (func3 == 3'b001) || (func3 == 3'b010) ||
                  (func3 == 3'b100) || (func3 == 3'b110);
    b_signed_in = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    a_neg_in    = a_signed_in & Data1[XLEN-1];
    b_neg_in    = b_signed_in & Data2[XLEN-1];
    a_mag       = a_neg_in ? -Data1 : Data1;
    b_mag       = b_neg_in ? -Data2 : Data2;
    // Remainder takes the dividend's sign; everything else the XOR of both signs
    res_neg_in  = (is_div_in && func3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    div_zero    = is_div_in && (Data2 == '0);
    div_ovf     = is_div_in && !func3[0] && (Data1 == MinNeg) && (Data2 == '1);
    if (div_zero) begin
      special_res = func3[1] ? Data1 : '1;
    end else begin
      special_res = func3[1] ? '0 : MinNeg;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_fix;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_fix  = res_neg_in ? -fast_prod : fast_prod;
    fast_res  = (func3 == 3'b000) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
  end
`endif

  // One radix-2 step: hi/lo form the product (multiply) or remainder/quotient (divide)
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, final_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[XLEN];
    if (op_q[2]) begin
      step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    div_sel  = op_q[1] ? step_hi : step_lo;
    div_fix  = neg_q ? -div_sel : div_sel;
    if (op_q[2]) begin
      final_res = div_fix;
    end else if (op_q == 3'b000) begin
      final_res = prod_fix[XLEN-1:0];
    end else begin
      final_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d  = func3;
          rd_d  = rd;
          neg_d = res_neg_in;
          hi_d  = '0;
          lo_d  = a_mag;
          b_d   = b_mag;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            rd_out_d = rd;
            state_d  = StDone;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!func3[2]) begin
            result_d = fast_res;
            rd_out_d = rd;
            state_d  = StDone;
          end
`endif
          else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            result_d = final_res;
            rd_out_d = rd_q;
            state_d  = StDone;
          end
        end
      end
      // start still shows the retiring instruction here, so it is ignored
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Nothing is captured while Reset is low, so the front end must not be held
  assign stall        = Reset & (((state_q == StIdle) & start & ~flush) | (state_q == StBusy));
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule
